oram_access_ctrl: RTL
=====================

# oram_access_ctrl

Sequencing controller for the Path-ORAM tree. It accepts one block read or write at a time and owns the position map and leaf RNG. It runs the full access on an external single-port bucket memory: path fetch, remap, root put-back, then one random-path flush. It sits between the client request port and the bucket SRAM holding the `(2^D)-1` tree nodes.

## Interface
- `A`, 8, bytes per block
- `D`, 6, tree depth; block number is D bits, leaf/pos is D-1 bits
- `K`, 3, tuples per bucket
- `clk` in 1, clock
- `rst_n` in 1, asynchronous active-low reset
- `req_valid` in 1, request valid
- `req_ready` out 1, high only in IDLE
- `req_we` in 1, 1 = write, 0 = read
- `req_blk` in D, block number
- `req_wdata` in 8A, write data
- `resp_valid` out 1, response valid; held until `resp_ready`
- `resp_ready` in 1, response accept
- `resp_hit` out 1, block was found in the tree
- `resp_rdata` out 8A, block value before this access (0 on miss)
- `mem_addr` out D, bucket index (node-1, heap order)
- `mem_rd` out 1, read strobe; `mem_rdata` valid the next cycle
- `mem_wr` out 1, write strobe
- `mem_wdata` out BW, bucket write data
- `mem_rdata` in BW, bucket read data
- `overflow` out 1, sticky; a put-back found the root full

BW = K*TW, where TW = 1 + (D-1) + D + 8A. Tuple fields, MSB to LSB: `valid`, `pos`, `blk`, `data`. Slot j occupies bits `[j*TW +: TW]`.

## Operation
- **Node indexing:** root node = 1. At level l the child is `2*node + pos[l]` (pos LSB is used first). Address = node-1.
- **Position map:** 2^D entries of {valid, pos}. All entries are invalid at reset.
- **LFSR:** 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1. It advances only when consumed. A leaf value is `lfsr[D-2:0]`.
- **IDLE:** a request is accepted when `req_valid && req_ready`. Blk, we and wdata are latched.
- **POSMAP:** read the entry. If it is invalid, take an LFSR leaf as p.
- **PATH:** visit levels 0..D-1 along p. Per node: ISSUE (`mem_rd`), CAPTURE (scan all K slots), WRITE (`mem_wr`, bucket write-back). A slot with `valid && blk==req_blk && pos==p` is a hit: capture its data, clear its valid. There is at most one hit per path.
- **REMAP:** take a new LFSR leaf p'. Write {1, p'} to the position map. The new tuple is {1, p', blk, we ? wdata : (hit ? captured : 0)}.
- **PUT:** read the root and place the new tuple in the lowest-index empty slot, then write it back. If no slot is empty, the tuple is dropped and `overflow` is set.
- **FLUSH:** take an LFSR leaf p*. For each level l = 0..D-2:
  - Read the parent node on the p* path (ISSUE, CAPTURE), then its child (ISSUE, CAPTURE).
  - Scan parent slots in ascending order. A valid tuple with `pos[l]==p*[l]` moves to the child's lowest-index empty slot and its parent copy is invalidated.
  - If the child is full, the tuple stays in the parent.
  - Write the child, then write the parent.
- **RESP:** assert `resp_valid`, return to IDLE on `resp_ready`.

## Timing
- **Reset values:** `req_ready`=1; `resp_valid`, `resp_hit`, `resp_rdata`, `mem_rd`, `mem_wr`, `mem_addr`, `mem_wdata` and `overflow` all 0. Position map invalid, LFSR = 16'hACE1.
- **Latency:** accept is cycle 0.
  - POSMAP: cycle 1
  - PATH: cycles 2..3D+1
  - REMAP: cycle 3D+2
  - PUT: 3 cycles
  - FLUSH: 6(D-1) cycles
  - `resp_valid` first high at cycle 9D (54 with defaults).
- `mem_rd` and `mem_wr` are never high together. At most one memory op per cycle.
- While the response is stalled, `resp_*` are stable and `req_ready`=0.
- Reset mid-access aborts immediately. Memory contents may be left partially updated; the position map is cleared regardless.
- `overflow` is cleared only by reset.

## Configuration
- **`ORAM_LFSR_SEED_EN` defined:** adds ports `seed_load` (in 1) and `seed` (in 16). A synchronous `seed_load` pulse in IDLE loads `seed` into the LFSR; a seed of 0 loads 16'hACE1 instead. `seed_load` is ignored in other states.
- **Undefined:** no extra ports; the LFSR starts only from 16'hACE1.

## Structure
- Package `oramPkg` holds the parameters, the tuple/bucket packed typedefs, TW, BW, the LFSR reset constant and the state enum.
- Sub-module `oram_lfsr` (16-bit, `step` input, optional load) generates leaves.
- The position map and FSM live in `oram_access_ctrl`.

## Test plan
All scenarios use A=8, D=6, K=3, with a bucket-memory model having 1-cycle read latency.
- **Reset:** with no stimulus, `req_ready`=1 and all other outputs are 0.
- **Write then read:** write blk 5 data 64'h1122334455667788, then read blk 5. Read response has `resp_hit`=1 and rdata equals the written value. Each response appears exactly 54 cycles after accept.
- **First-touch read:** reading never-written blk 9 returns `resp_hit`=0 and rdata=0. A second read of blk 9 returns `resp_hit`=1 and rdata=0.
- **Overflow:** preload every bucket with 3 valid tuples of other block numbers, then access blk 0. `overflow` rises during PUT and stays 1 through further accesses until reset.
- **Flush:** load a known seed, giving a predictable p*. Preload the root with tuple X (`pos[0]`=p*[0]) and tuple Y (`pos[0]`≠p*[0]), and the child empty. After the access, X is at node 2+p*[0] or deeper along p*, and Y is still in the root.
- **Backpressure:** hold `resp_ready`=0 for 10 cycles. `resp_valid` and rdata stay stable, `req_ready`=0, and a concurrent `req_valid` is not accepted.

Source files
------------

// File: rtl/oram_access_ctrl_pkg.sv
// oramPkg: shared parameters, tuple/bucket layouts, LFSR constants and the
// controller state encoding for the Path-ORAM access controller.
//
// Contents:
//   A, D, K     - bytes per block, tree depth, tuples per bucket
//   PW, DW      - leaf/pos width (D-1) and data width (8A)
//   TW, BW      - tuple width and bucket width (K*TW)
//   tuple_t     - {valid, pos, blk, data}, MSB to LSB
//   bucket_t    - K tuples; slot j sits at bits [j*TW +: TW]
//   state_e     - controller FSM states
//   pos_bit()   - bit l of a leaf label (LSB selects the first branch)
package oramPkg;
    localparam int A   = 8;
    localparam int D   = 6;
    localparam int K   = 3;
    localparam int PW  = D - 1;
    localparam int DW  = 8 * A;
    localparam int TW  = 1 + PW + D + DW;
    localparam int BW  = K * TW;
    localparam int LW  = $clog2(D);
    localparam int NBLK = 1 << D;

    localparam logic [15:0] LFSR_RESET = 16'hACE1;
    // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form).
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;

    typedef struct packed {
        logic          valid;
        logic [PW-1:0] pos;
        logic [D-1:0]  blk;
        logic [DW-1:0] data;
    } tuple_t;

    typedef tuple_t [K-1:0] bucket_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_POSMAP,
        S_PATH_ISSUE,
        S_PATH_CAP,
        S_PATH_WR,
        S_REMAP,
        S_PUT_ISSUE,
        S_PUT_CAP,
        S_PUT_WR,
        S_FL_PISSUE,
        S_FL_PCAP,
        S_FL_CISSUE,
        S_FL_CCAP,
        S_FL_CWR,
        S_FL_PWR,
        S_RESP
    } state_e;

    function automatic logic pos_bit(input logic [PW-1:0] p, input logic [LW-1:0] l);
        return p[l];
    endfunction
endpackage

// File: rtl/oram_lfsr.sv
// oram_lfsr: 16-bit Galois LFSR that supplies random leaf labels.
// The register only moves when a leaf is consumed (step_i) or reloaded.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset (loads LFSR_RESET)
//   step_i      - advance one step; the current leaf_o is the consumed value
//   load_i      - load seed_i (a zero seed loads LFSR_RESET); wins over step_i
//   seed_i      - seed value
//   leaf_o      - current leaf, low PW bits of the register
module oram_lfsr
    import oramPkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          step_i,
    input  logic          load_i,
    input  logic [15:0]   seed_i,
    output logic [PW-1:0] leaf_o
);
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            // An all-zero state would lock the LFSR, so zero maps to the reset seed.
            lfsr_d = (seed_i == 16'h0) ? LFSR_RESET : seed_i;
        end else if (step_i) begin
            lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_q <= LFSR_RESET;
        else        lfsr_q <= lfsr_d;
    end

    assign leaf_o = lfsr_q[PW-1:0];
endmodule

// File: rtl/oram_access_ctrl.sv
// oram_access_ctrl: Path-ORAM access sequencer. Accepts one block read or
// write, looks up / assigns the leaf in the position map, fetches the path,
// remaps the block, puts it back into the root, then flushes one random path.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; req_ready is high only in IDLE, and resp_valid/resp_hit/
// resp_rdata hold steady until the edge where resp_ready is seen high.
//
// Ports:
//   req_valid/req_ready/req_we/req_blk/req_wdata - client request
//   resp_valid/resp_ready/resp_hit/resp_rdata    - client response
//   mem_addr/mem_rd/mem_wr/mem_wdata/mem_rdata   - single-port bucket SRAM,
//                                                  read data one cycle after mem_rd
//   overflow                                     - sticky: root was full on put-back
//   seed_load/seed                               - only with ORAM_LFSR_SEED_EN
//
// Build option: define ORAM_LFSR_SEED_EN to add the LFSR seed load port.
module oram_access_ctrl
    import oramPkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [D-1:0]  req_blk,
    input  logic [DW-1:0] req_wdata,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic          resp_hit,
    output logic [DW-1:0] resp_rdata,
    output logic [D-1:0]  mem_addr,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [BW-1:0] mem_wdata,
    input  logic [BW-1:0] mem_rdata,
    output logic          overflow
`ifdef ORAM_LFSR_SEED_EN
    ,
    input  logic          seed_load,
    input  logic [15:0]   seed
`endif
);
    state_e        state_q, state_d;
    logic [D-1:0]  blk_q, blk_d;
    logic          we_q, we_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [PW-1:0] pos_q, pos_d;       // p during the path, p' during put, p* during flush
    logic [LW-1:0] lvl_q, lvl_d;
    logic [D-1:0]  node_q, node_d;     // heap index, root = 1
    logic          hit_q, hit_d;
    logic [DW-1:0] rdata_q, rdata_d;
    bucket_t       buck_q, buck_d;     // path bucket / flush parent
    bucket_t       chld_q, chld_d;     // flush child
    logic          ovf_q, ovf_d;
    logic [NBLK-1:0] pm_vld_q;
    logic [PW-1:0]   pm_pos_q [NBLK];
    logic            pm_we;

    logic          lfsr_step, lfsr_load;
    logic [15:0]   lfsr_seed;
    logic [PW-1:0] leaf;
    logic [D-1:0]  child_node;

`ifdef ORAM_LFSR_SEED_EN
    assign lfsr_load = seed_load && (state_q == S_IDLE);
    assign lfsr_seed = seed;
`else
    assign lfsr_load = 1'b0;
    assign lfsr_seed = 16'h0;
`endif

    oram_lfsr u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .step_i (lfsr_step),
        .load_i (lfsr_load),
        .seed_i (lfsr_seed),
        .leaf_o (leaf)
    );

    // Next node along the current leaf: 2*node + pos[level].
    assign child_node = {node_q[D-2:0], pos_bit(pos_q, lvl_q)};

    assign resp_hit   = hit_q;
    assign resp_rdata = rdata_q;
    assign overflow   = ovf_q;

    always_comb begin
        bucket_t rb;
        bucket_t par;
        bucket_t chi;
        tuple_t  nt;
        logic    placed;

        state_d   = state_q;
        blk_d     = blk_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        pos_d     = pos_q;
        lvl_d     = lvl_q;
        node_d    = node_q;
        hit_d     = hit_q;
        rdata_d   = rdata_q;
        buck_d    = buck_q;
        chld_d    = chld_q;
        ovf_d     = ovf_q;
        pm_we     = 1'b0;
        lfsr_step = 1'b0;
        req_ready  = (state_q == S_IDLE);
        resp_valid = (state_q == S_RESP);
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        rb        = mem_rdata;
        par       = buck_q;
        chi       = mem_rdata;
        nt        = '0;
        placed    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    blk_d   = req_blk;
                    we_d    = req_we;
                    wdata_d = req_wdata;
                    hit_d   = 1'b0;
                    rdata_d = '0;
                    state_d = S_POSMAP;
                end
            end
            S_POSMAP: begin
                if (pm_vld_q[blk_q]) begin
                    pos_d = pm_pos_q[blk_q];
                end else begin
                    pos_d     = leaf;
                    lfsr_step = 1'b1;
                end
                node_d  = D'(1);
                lvl_d   = '0;
                state_d = S_PATH_ISSUE;
            end
            S_PATH_ISSUE: begin
                mem_rd   = 1'b1;
                mem_addr = node_q - D'(1);
                state_d  = S_PATH_CAP;
            end
            S_PATH_CAP: begin
                for (int j = 0; j < K; j++) begin
                    if (!placed && rb[j].valid && rb[j].blk == blk_q && rb[j].pos == pos_q) begin
                        placed      = 1'b1;
                        hit_d       = 1'b1;
                        rdata_d     = rb[j].data;
                        rb[j].valid = 1'b0;
                    end
                end
                buck_d  = rb;
                state_d = S_PATH_WR;
            end
            S_PATH_WR: begin
                mem_wr    = 1'b1;
                mem_addr  = node_q - D'(1);
                mem_wdata = buck_q;
                if (lvl_q == LW'(D - 1)) begin
                    state_d = S_REMAP;
                end else begin
                    node_d  = child_node;
                    lvl_d   = lvl_q + LW'(1);
                    state_d = S_PATH_ISSUE;
                end
            end
            S_REMAP: begin
                pos_d     = leaf;
                pm_we     = 1'b1;
                lfsr_step = 1'b1;
                node_d    = D'(1);
                state_d   = S_PUT_ISSUE;
            end
            S_PUT_ISSUE: begin
                mem_rd   = 1'b1;
                mem_addr = node_q - D'(1);
                state_d  = S_PUT_CAP;
            end
            S_PUT_CAP: begin
                nt.valid = 1'b1;
                nt.pos   = pos_q;
                nt.blk   = blk_q;
                nt.data  = we_q ? wdata_q : rdata_q;  // rdata_q is 0 on a miss
                for (int j = 0; j < K; j++) begin
                    if (!placed && !rb[j].valid) begin
                        rb[j]  = nt;
                        placed = 1'b1;
                    end
                end
                if (!placed) ovf_d = 1'b1;
                buck_d  = rb;
                state_d = S_PUT_WR;
            end
            S_PUT_WR: begin
                mem_wr    = 1'b1;
                mem_addr  = node_q - D'(1);
                mem_wdata = buck_q;
                pos_d     = leaf;        // p* for the flush
                lfsr_step = 1'b1;
                lvl_d     = '0;
                node_d    = D'(1);
                state_d   = S_FL_PISSUE;
            end
            S_FL_PISSUE: begin
                mem_rd   = 1'b1;
                mem_addr = node_q - D'(1);
                state_d  = S_FL_PCAP;
            end
            S_FL_PCAP: begin
                buck_d  = mem_rdata;
                state_d = S_FL_CISSUE;
            end
            S_FL_CISSUE: begin
                mem_rd   = 1'b1;
                mem_addr = child_node - D'(1);
                state_d  = S_FL_CCAP;
            end
            S_FL_CCAP: begin
                // Parent slots in ascending order; each eligible tuple takes the
                // lowest free child slot, or stays put when the child is full.
                for (int i = 0; i < K; i++) begin
                    if (par[i].valid && pos_bit(par[i].pos, lvl_q) == pos_bit(pos_q, lvl_q)) begin
                        placed = 1'b0;
                        for (int j = 0; j < K; j++) begin
                            if (!placed && !chi[j].valid) begin
                                chi[j] = par[i];
                                placed = 1'b1;
                            end
                        end
                        if (placed) par[i].valid = 1'b0;
                    end
                end
                buck_d  = par;
                chld_d  = chi;
                state_d = S_FL_CWR;
            end
            S_FL_CWR: begin
                mem_wr    = 1'b1;
                mem_addr  = child_node - D'(1);
                mem_wdata = chld_q;
                state_d   = S_FL_PWR;
            end
            S_FL_PWR: begin
                mem_wr    = 1'b1;
                mem_addr  = node_q - D'(1);
                mem_wdata = buck_q;
                if (lvl_q == LW'(D - 2)) begin
                    state_d = S_RESP;
                end else begin
                    node_d  = child_node;
                    lvl_d   = lvl_q + LW'(1);
                    state_d = S_FL_PISSUE;
                end
            end
            S_RESP: begin
                if (resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            blk_q    <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            pos_q    <= '0;
            lvl_q    <= '0;
            node_q   <= D'(1);
            hit_q    <= 1'b0;
            rdata_q  <= '0;
            buck_q   <= '0;
            chld_q   <= '0;
            ovf_q    <= 1'b0;
            pm_vld_q <= '0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            pos_q   <= pos_d;
            lvl_q   <= lvl_d;
            node_q  <= node_d;
            hit_q   <= hit_d;
            rdata_q <= rdata_d;
            buck_q  <= buck_d;
            chld_q  <= chld_d;
            ovf_q   <= ovf_d;
            if (pm_we) pm_vld_q[blk_q] <= 1'b1;
        end
    end

    // Leaf storage needs no reset: an entry is only read once its valid bit is set.
    always_ff @(posedge clk) begin
        if (pm_we) pm_pos_q[blk_q] <= leaf;
    end
endmodule
